// File: rtl/poly_basemul.sv
// Pointwise multiplication of two ML-KEM-768 NTT-domain polynomials. One fqmul
// (Montgomery multiply) datapath is time-shared over 5 steps per coefficient pair.
module poly_basemul (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] a_in  [0:255],
  input  logic signed [15:0] b_in  [0:255],
  output logic               done,
  output logic signed [15:0] r_out [0:255],
  output logic [1:0]         o_dbg_state
);

  localparam logic [15:0] QINV     = 16'hF301;  // -3327 mod 2^16
  localparam logic [6:0]  LAST_PAIR = 7'd127;

  // zetas[64..127] of the reference Montgomery table
  localparam logic signed [15:0] ZETAS [0:63] = '{
    -16'sd1103,  16'sd430,   16'sd555,   16'sd843,  -16'sd1251,  16'sd871,   16'sd1550,  16'sd105,
     16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,   16'sd1574,  16'sd1653,
    -16'sd246,   16'sd778,   16'sd1159, -16'sd147,  -16'sd777,   16'sd1483, -16'sd602,   16'sd1119,
    -16'sd1590,  16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,  -16'sd75,
     16'sd817,   16'sd1097,  16'sd603,   16'sd610,   16'sd1322, -16'sd1285, -16'sd1465,  16'sd384,
    -16'sd1215, -16'sd136,   16'sd1218, -16'sd1335, -16'sd874,   16'sd220,  -16'sd1187, -16'sd1659,
    -16'sd1185, -16'sd1530, -16'sd1278,  16'sd794,  -16'sd1510, -16'sd854,  -16'sd870,   16'sd478,
    -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958,  -16'sd1460,  16'sd1522,  16'sd1628
  };

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state, w_next;
  logic               w_load;
  logic [6:0]         r_pair;
  logic [2:0]         r_step;
  logic signed [15:0] r_a [0:255];
  logic signed [15:0] r_b [0:255];
  logic signed [15:0] r_t, r_r0, r_u;

  logic [7:0]         w_i0, w_i1;
  logic signed [15:0] w_a0, w_a1, w_b0, w_b1;
  logic signed [15:0] w_zeta_raw, w_zeta;
  logic signed [15:0] w_x, w_y;
  logic signed [31:0] w_x32, w_y32, w_p, w_tl_ext;
  logic [15:0]        w_tl, w_tq_hi;
  logic signed [15:0] w_f;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_step == 3'd4 && r_pair == LAST_PAIR) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    done        = (r_state == S_DONE);
    w_load      = start && (r_state != S_RUN);
    o_dbg_state = r_state;
  end

  // ---------------- operand selection ----------------
  assign w_i0       = {r_pair, 1'b0};
  assign w_i1       = {r_pair, 1'b1};
  assign w_a0       = r_a[w_i0];
  assign w_a1       = r_a[w_i1];
  assign w_b0       = r_b[w_i0];
  assign w_b1       = r_b[w_i1];
  assign w_zeta_raw = ZETAS[r_pair[6:1]];
  assign w_zeta     = r_pair[0] ? -w_zeta_raw : w_zeta_raw;

  always_comb begin
    w_x = w_a1;
    w_y = w_b1;
    case (r_step)
      3'd1:    begin w_x = r_t;  w_y = w_zeta; end
      3'd2:    begin w_x = w_a0; w_y = w_b0;   end
      3'd3:    begin w_x = w_a0; w_y = w_b1;   end
      3'd4:    begin w_x = w_a1; w_y = w_b0;   end
      default: ;
    endcase
  end

  // ---------------- fqmul ----------------
  assign w_x32    = {{16{w_x[15]}}, w_x};
  assign w_y32    = {{16{w_y[15]}}, w_y};
  assign w_p      = w_x32 * w_y32;
  assign w_tl     = 16'(w_p[15:0] * QINV);
  assign w_tl_ext = {{16{w_tl[15]}}, w_tl};
  // p and t*q agree in their low 16 bits, so (p - t*q) >>> 16 == p_hi - (t*q)_hi exactly.
  assign w_tq_hi  = 16'((w_tl_ext * 32'sd3329) >>> 16);
  assign w_f      = w_p[31:16] - w_tq_hi;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '{default: '0};
      r_b    <= '{default: '0};
      r_out  <= '{default: '0};
      r_t    <= '0;
      r_r0   <= '0;
      r_u    <= '0;
      r_pair <= '0;
      r_step <= '0;
    end else if (w_load) begin
      r_a    <= a_in;
      r_b    <= b_in;
      r_pair <= '0;
      r_step <= '0;
    end else if (r_state == S_RUN) begin
      case (r_step)
        3'd0:    r_t  <= w_f;
        3'd1:    r_t  <= w_f;
        3'd2:    r_r0 <= r_t + w_f;
        3'd3:    r_u  <= w_f;
        3'd4:    begin
          r_out[w_i0] <= r_r0;
          r_out[w_i1] <= r_u + w_f;
        end
        default: ;
      endcase
      if (r_step == 3'd4) begin
        r_step <= '0;
        r_pair <= r_pair + 7'd1;
      end else begin
        r_step <= r_step + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_poly_basemul.sv
// Directed and model-checked bench for poly_basemul: sparse hand-computed vectors,
// random operands against a C-style reference, mid-run start/operand changes and reset.
module tb_poly_basemul;

  localparam int N   = 256;
  localparam int LAT = 640;

  logic               clk   = 1'b0;
  logic               rst   = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] a_in  [0:N-1];
  logic signed [15:0] b_in  [0:N-1];
  logic               done;
  logic signed [15:0] r_out [0:N-1];
  logic [1:0]         o_dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  shortint     exp_r [0:N-1];

  int zetas_hi [0:63] = '{
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  typedef struct {
    string name;
    int a_i0; int a_v0; int a_i1; int a_v1;
    int b_i0; int b_v0; int b_i1; int b_v1;
    int e_i0; int e_v0; int e_i1; int e_v1;
  } vec_t;

  vec_t vecs [0:8];

  poly_basemul dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_in        (a_in),
    .b_in        (b_in),
    .done        (done),
    .r_out       (r_out),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic shortint fqmul_m(input int a, input int b);
    int      p;
    shortint t;
    int      m;
    p = a * b;
    t = shortint'(p * -3327);
    m = p - int'(t) * 3329;
    return shortint'(m >>> 16);
  endfunction

  task automatic model_run();
    int      zeta;
    shortint r0, r1;
    for (int k = 0; k < 128; k++) begin
      zeta = (k % 2 == 0) ? zetas_hi[k / 2] : -zetas_hi[k / 2];
      r0 = fqmul_m(int'(a_in[2*k+1]), int'(b_in[2*k+1]));
      r0 = fqmul_m(int'(r0), zeta);
      r0 = shortint'(r0 + fqmul_m(int'(a_in[2*k]), int'(b_in[2*k])));
      r1 = fqmul_m(int'(a_in[2*k]), int'(b_in[2*k+1]));
      r1 = shortint'(r1 + fqmul_m(int'(a_in[2*k+1]), int'(b_in[2*k])));
      exp_r[2*k]   = r0;
      exp_r[2*k+1] = r1;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(input string nm,
                              input int ai0, input int av0, input int ai1, input int av1,
                              input int bi0, input int bv0, input int bi1, input int bv1,
                              input int ei0, input int ev0, input int ei1, input int ev1);
    vec_t v;
    v.name = nm;
    v.a_i0 = ai0; v.a_v0 = av0; v.a_i1 = ai1; v.a_v1 = av1;
    v.b_i0 = bi0; v.b_v0 = bv0; v.b_i1 = bi1; v.b_v1 = bv1;
    v.e_i0 = ei0; v.e_v0 = ev0; v.e_i1 = ei1; v.e_v1 = ev1;
    return v;
  endfunction

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < N; i++) exp_r[i] = 0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i] = 16'(int'($urandom_range(0, 6658)) - 3329);
      b_in[i] = 16'(int'($urandom_range(0, 6658)) - 3329);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic check_result(input string nm);
    int          errs;
    int          first;
    logic [15:0] e;
    logic [15:0] first_e;
    errs    = 0;
    first   = -1;
    first_e = '0;
    for (int i = 0; i < N; i++) exp_q.push_back(16'(exp_r[i]));
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      if (r_out[i] !== e) begin
        if (first < 0) begin
          first   = i;
          first_e = e;
        end
        errs++;
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s: %0d coefficients differ, first r_out[%0d]=%0d expected %0d",
               nm, errs, first, $signed(r_out[first]), $signed(first_e));
    end
  endtask

  // Counts edges after the start edge until done; optionally pulses start and
  // scrambles the operands at cycle inject_at while the block is running.
  task automatic wait_done(input string nm, input int inject_at);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == inject_at) begin
        randomize_ops();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 1000);
    start = 1'b0;
    check_val({nm, " latency"}, cyc, LAT);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_ops();
    vecs[0] = mk("all_zero",     -1, 0, -1, 0,   -1, 0, -1, 0,   -1, 0,    -1, 0);
    vecs[1] = mk("a0b0",          0, 1, -1, 0,    0, 1, -1, 0,    0, 169,  -1, 0);
    vecs[2] = mk("zeta_sign",     1, 1,  3, 1,    1, 1,  3, 1,    0, -456,  2, 456);
    vecs[3] = mk("cross_a0b1",    0, 1, -1, 0,    1, 1, -1, 0,    1, 169,  -1, 0);
    vecs[4] = mk("neg_scale",     0, -1, -1, 0,   0, 2, -1, 0,    0, -338, -1, 0);
    vecs[5] = mk("zeta_430",      5, 1,  7, 1,    5, 1,  7, 1,    4, 549,   6, -549);
    vecs[6] = mk("last_pair",   255, 1, -1, 0,  255, 1, -1, 0,  254, -1165, -1, 0);
    vecs[7] = mk("full_pair0",    0, 1,  1, 1,    0, 1,  1, 1,    0, -287,  1, 338);
    vecs[8] = mk("last_cross",  255, 1, -1, 0,  254, 1, -1, 0,  255, 169,  -1, 0);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset done", int'(done), 0);
    check_val("reset state", int'(o_dbg_state), 0);
    clear_exp();
    check_result("reset r_out");
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 9; v++) begin
      clear_ops();
      if (vecs[v].a_i0 >= 0) a_in[vecs[v].a_i0] = 16'(vecs[v].a_v0);
      if (vecs[v].a_i1 >= 0) a_in[vecs[v].a_i1] = 16'(vecs[v].a_v1);
      if (vecs[v].b_i0 >= 0) b_in[vecs[v].b_i0] = 16'(vecs[v].b_v0);
      if (vecs[v].b_i1 >= 0) b_in[vecs[v].b_i1] = 16'(vecs[v].b_v1);
      clear_exp();
      if (vecs[v].e_i0 >= 0) exp_r[vecs[v].e_i0] = shortint'(vecs[v].e_v0);
      if (vecs[v].e_i1 >= 0) exp_r[vecs[v].e_i1] = shortint'(vecs[v].e_v1);
      pulse_start();
      wait_done(vecs[v].name, -1);
      check_result(vecs[v].name);
    end

    // DONE holds with a stable result while operands change and start stays low
    randomize_ops();
    repeat (10) @(posedge clk);
    #1;
    check_val("done hold", int'(done), 1);
    check_val("done state", int'(o_dbg_state), 2);
    check_result("hold r_out");

    // random operands; start pulse plus operand change injected mid-run
    for (int r = 0; r < 25; r++) begin
      randomize_ops();
      model_run();
      pulse_start();
      wait_done($sformatf("rand%0d", r), 100 + r * 17);
      check_result($sformatf("rand%0d", r));
    end

    // asynchronous reset at pair 50
    randomize_ops();
    pulse_start();
    for (int c = 0; c < 250; c++) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("midrun reset done", int'(done), 0);
    check_val("midrun reset state", int'(o_dbg_state), 0);
    clear_exp();
    check_result("midrun reset r_out");
    @(negedge clk);
    rst = 1'b1;

    randomize_ops();
    model_run();
    pulse_start();
    wait_done("restart", -1);
    check_result("restart");

    randomize_ops();
    model_run();
    pulse_start();
    wait_done("back_to_back", -1);
    check_result("back_to_back");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
